// File: rtl/if_fetch.sv
// Instruction fetch front end: PC, I-cache req/ack, fetch queue,
// redirect squash, and the {pc, ir} pair handed to predecode.
module if_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          FQ_DEPTH = 2,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ic_req,
  output logic [63:0] ic_addr,
  input  logic        ic_ack,
  input  logic [31:0] ic_data,
  input  logic        br_taken,
  input  logic [63:0] br_addr,
  input  logic        stall,
  output logic [63:0] pc_out,
  output logic [31:0] ir_out
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FQ_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FLUSH
  } state_t;

  state_t        state, state_nx;
  logic [63:0]   pc, pc_nx, pc_inc;
  logic          req_nx;
  logic [63:0]   addr_nx;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, cnt_nx;
  logic          push, pop;

  logic [63:0] fq_pc [FQ_DEPTH];
  logic [31:0] fq_ir [FQ_DEPTH];

  assign pc_inc = pc + 64'd4;

  always_comb begin
    push = (state == REQ) && ic_ack && !br_taken;
    pop  = !br_taken && !stall && (count != '0);
    cnt_nx = count + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    req_nx   = ic_req;
    addr_nx  = ic_addr;
    if (br_taken) begin
      pc_nx = br_addr & ~64'h3;
      unique case (state)
        REQ: begin
          if (ic_ack) begin
            req_nx   = 1'b0;
            state_nx = IDLE;
          end else begin
            state_nx = FLUSH;
          end
        end
        FLUSH: begin
          if (ic_ack) begin
            req_nx   = 1'b0;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          if (cnt_nx < FULL) begin
            req_nx   = 1'b1;
            addr_nx  = pc;
            state_nx = REQ;
          end
        end
        REQ: begin
          if (ic_ack) begin
            pc_nx = pc_inc;
            if (cnt_nx < FULL) begin
              addr_nx = pc_inc;
            end else begin
              req_nx   = 1'b0;
              state_nx = IDLE;
            end
          end
        end
        FLUSH: begin
          // squashed fetch returns; its data is dropped
          if (ic_ack) begin
            req_nx   = 1'b0;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (push) begin
      fq_pc[tail] <= ic_addr;
      fq_ir[tail] <= ic_data;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      ic_req  <= 1'b0;
      ic_addr <= '0;
      pc_out  <= '0;
      ir_out  <= NOP;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      ic_req  <= req_nx;
      ic_addr <= addr_nx;
      if (br_taken) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        if (!stall) ir_out <= NOP;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
        count <= cnt_nx;
        if (!stall) begin
          if (count != '0) begin
            pc_out <= fq_pc[head];
            ir_out <= fq_ir[head];
          end else begin
            ir_out <= NOP;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: scoreboard queue filled by stimulus,
// drained by an output monitor, plus direct checks on fetch signals.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BAD = 32'h0BAD_0093;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ic_req;
  logic [63:0] ic_addr;
  logic        ic_ack = 1'b0;
  logic [31:0] ic_data = '0;
  logic        br_taken = 1'b0;
  logic [63:0] br_addr = '0;
  logic        stall = 1'b0;
  logic [63:0] pc_out;
  logic [31:0] ir_out;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ir;
  } ent_t;

  ent_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic live = 1'b0;

  logic [31:0] dat [7] = '{
    32'h00A0_0093, 32'h0010_0113, 32'h0020_0193, 32'h0030_0213,
    32'h0040_0293, 32'h0050_0313, 32'h0060_0393
  };
  localparam logic [31:0] A0 = 32'h00B0_0393;
  localparam logic [31:0] A1 = 32'h00C0_0413;
  localparam logic [31:0] B0 = 32'h00D0_0493;
  localparam logic [31:0] C0 = 32'h00E0_0513;

  if_fetch dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ic_req   (ic_req),
    .ic_addr  (ic_addr),
    .ic_ack   (ic_ack),
    .ic_data  (ic_data),
    .br_taken (br_taken),
    .br_addr  (br_addr),
    .stall    (stall),
    .pc_out   (pc_out),
    .ir_out   (ir_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic a, input logic [31:0] d,
                      input logic b, input logic [63:0] ba,
                      input logic s);
    ic_ack   = a;
    ic_data  = d;
    br_taken = b;
    br_addr  = ba;
    stall    = s;
    @(posedge clk);
  endtask

  // an unstalled edge with a non-bubble output presents a new entry
  always @(negedge clk) live = rst_n && !stall;

  always @(posedge clk) begin
    if (live && ir_out !== NOP) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_extra: got pc=%h ir=%h expected none",
                 pc_out, ir_out);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("mon_pc", pc_out, e.pc);
        chk("mon_ir", {32'h0, ir_out}, {32'h0, e.ir});
      end
    end
  end

  initial begin
    logic [63:0] epc;
    @(posedge clk);
    @(posedge clk);
    chk("rst_req", {63'h0, ic_req}, 64'h0);
    chk("rst_addr", ic_addr, 64'h0);
    chk("rst_pc_out", pc_out, 64'h0);
    chk("rst_ir_out", {32'h0, ir_out}, {32'h0, NOP});

    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("first_req", {63'h0, ic_req}, 64'h1);

    epc = 64'h8000_0000;
    for (int i = 0; i < 6; i++) begin
      chk("seq_addr", ic_addr, epc);
      exp_q.push_back({epc, dat[i]});
      step(1, dat[i], 0, 0, 0);
      epc += 64'd4;
    end
    chk("lat_pc", pc_out, 64'h8000_0010);
    chk("lat_ir", {32'h0, ir_out}, {32'h0, dat[4]});

    exp_q.push_back({epc, dat[6]});
    step(1, dat[6], 0, 0, 1);
    chk("stall_req", {63'h0, ic_req}, 64'h0);
    for (int k = 0; k < 4; k++) begin
      step(1, BAD, 0, 0, 1);
      chk("stall_req", {63'h0, ic_req}, 64'h0);
      chk("stall_pc", pc_out, 64'h8000_0010);
      chk("stall_ir", {32'h0, ir_out}, {32'h0, dat[4]});
    end

    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 0);
      chk("wait_ir", {32'h0, ir_out}, {32'h0, NOP});
      chk("wait_pc", pc_out, 64'h8000_0018);
      chk("wait_req", {63'h0, ic_req}, 64'h1);
      chk("wait_addr", ic_addr, 64'h8000_001C);
    end

    step(0, 0, 1, 64'h8000_1002, 0);
    chk("flush_req", {63'h0, ic_req}, 64'h1);
    chk("flush_addr", ic_addr, 64'h8000_001C);
    chk("flush_ir", {32'h0, ir_out}, {32'h0, NOP});
    step(1, BAD, 0, 0, 0);
    chk("flush_drop_req", {63'h0, ic_req}, 64'h0);
    chk("flush_drop_ir", {32'h0, ir_out}, {32'h0, NOP});
    step(0, 0, 0, 0, 0);
    chk("redir_req", {63'h0, ic_req}, 64'h1);
    chk("redir_addr", ic_addr, 64'h8000_1000);
    chk("redir_ir", {32'h0, ir_out}, {32'h0, NOP});

    step(1, A0, 0, 0, 1);
    step(1, A1, 1, 64'h8000_2000, 1);
    chk("brack_req", {63'h0, ic_req}, 64'h0);
    step(0, 0, 0, 0, 0);
    chk("brack_addr", ic_addr, 64'h8000_2000);
    chk("brack_ir", {32'h0, ir_out}, {32'h0, NOP});
    exp_q.push_back({64'h8000_2000, B0});
    step(1, B0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("brack_pc_out", pc_out, 64'h8000_2000);
    chk("brack_ir_out", {32'h0, ir_out}, {32'h0, B0});

    step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    step(1, BAD, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("wrap_addr_hi", ic_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    exp_q.push_back({64'hFFFF_FFFF_FFFF_FFFC, C0});
    step(1, C0, 0, 0, 0);
    chk("wrap_addr_0", ic_addr, 64'h0);
    chk("wrap_req", {63'h0, ic_req}, 64'h1);
    step(0, 0, 0, 0, 0);
    chk("wrap_ir", {32'h0, ir_out}, {32'h0, C0});

    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {63'h0, ic_req}, 64'h0);
    chk("arst_ir", {32'h0, ir_out}, {32'h0, NOP});
    chk("arst_pc", pc_out, 64'h0);
    chk("arst_addr", ic_addr, 64'h0);
    ic_ack  = 1'b1;
    ic_data = BAD;
    @(posedge clk);
    @(posedge clk);
    chk("arst_ack_req", {63'h0, ic_req}, 64'h0);
    chk("arst_ack_ir", {32'h0, ir_out}, {32'h0, NOP});
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("rerst_req", {63'h0, ic_req}, 64'h1);
    chk("rerst_addr", ic_addr, 64'h8000_0000);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("sb_empty", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
